// File: rtl/reorder_buffer_pkg.sv
// Shared ROB sizing, the tag-0 "no dependency" constant and the per-entry record.
package reorder_buffer_pkg;

    localparam int DEF_ROB_SIZE = 16;
    localparam int DEF_TAG_W    = 5;
    localparam int DATA_W       = 32;
    localparam int REG_W        = 5;

    localparam logic [DEF_TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic [REG_W-1:0]  rd;
        logic              is_branch;
        logic              mispredict;
        logic [DATA_W-1:0] value;
        logic [DATA_W-1:0] target;
    } rob_entry_t;

    localparam rob_entry_t ENTRY_CLEAR = '0;

endpackage

// File: rtl/reorder_buffer_rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the circular ROB; pointers move on the edge after alloc/retire.
// Full/empty are decoded combinationally from the count; clear wins over alloc/retire; en low freezes all.
module rob_ptr_ctrl #(
    parameter int ROB_SIZE = 16,
    parameter int IDX_W    = 4,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             alloc,
    input  logic             retire,
    input  logic             clear,
    output logic [IDX_W-1:0] head,
    output logic [IDX_W-1:0] tail,
    output logic             full,
    output logic             empty
);

    logic [CNT_W-1:0] count;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(ROB_SIZE - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (en) begin
            if (clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (alloc)
                    tail <= wrap_inc(tail);
                if (retire)
                    head <= wrap_inc(head);
                // simultaneous alloc and retire leaves occupancy unchanged
                case ({alloc, retire})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    assign full  = (count == CNT_W'(ROB_SIZE));
    assign empty = (count == '0);

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: tag alloc, CDB capture, 1-cycle registered commit/flush; dispatcher stalls on rob_full.
// Optional ROB_CDB_BYPASS_EN: queries and head retirement also see the current-cycle CDB broadcast.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE = DEF_ROB_SIZE,
    parameter int TAG_W    = DEF_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              disp_valid,
    input  logic [REG_W-1:0]  disp_rd,
    input  logic              disp_is_branch,
    input  logic [DATA_W-1:0] disp_pc_next,
    output logic              rob_full,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_mispredict,
    input  logic [DATA_W-1:0] cdb_target,
    input  logic [TAG_W-1:0]  query_tag1,
    input  logic [TAG_W-1:0]  query_tag2,
    output logic              query_rdy1,
    output logic              query_rdy2,
    output logic [DATA_W-1:0] query_data1,
    output logic [DATA_W-1:0] query_data2,
    output logic              commit_valid,
    output logic [REG_W-1:0]  commit_dest,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [DATA_W-1:0] commit_data,
    output logic              flush,
    output logic [DATA_W-1:0] flush_pc
);

    localparam int IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
    localparam int CNT_W = $clog2(ROB_SIZE + 1);

    rob_entry_t        ent [ROB_SIZE];
    rob_entry_t        hd;
    rob_entry_t        new_ent;
    logic [IDX_W-1:0]  head;
    logic [IDX_W-1:0]  tail;
    logic              full;
    logic              empty;
    logic [TAG_W-1:0]  head_tag;
    logic [IDX_W-1:0]  cdb_idx;
    logic              head_cdb;
    logic              retire;
    logic              flush_now;
    logic              alloc;
    logic              cdb_wr;
    logic [DATA_W-1:0] ret_value;
    logic [DATA_W-1:0] ret_target;
    logic              ret_mp;

    function automatic logic tag_ok(input logic [TAG_W-1:0] t);
        return (t != TAG_W'(TAG_NONE)) && (t <= TAG_W'(ROB_SIZE));
    endfunction

    function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_W-1:0] t);
        return IDX_W'(t - TAG_W'(1));
    endfunction

    rob_ptr_ctrl #(
        .ROB_SIZE (ROB_SIZE),
        .IDX_W    (IDX_W),
        .CNT_W    (CNT_W)
    ) u_ptr (
        .clk    (clk),
        .rst    (rst),
        .en     (rdy),
        .alloc  (alloc),
        .retire (retire),
        .clear  (flush_now),
        .head   (head),
        .tail   (tail),
        .full   (full),
        .empty  (empty)
    );

    assign hd        = ent[head];
    assign head_tag  = TAG_W'(head) + TAG_W'(1);
    assign alloc_tag = TAG_W'(tail) + TAG_W'(1);
    assign rob_full  = full;
    assign cdb_idx   = tag_idx(cdb_tag);

`ifdef ROB_CDB_BYPASS_EN
    assign head_cdb = cdb_valid && (cdb_tag == head_tag);
`else
    assign head_cdb = 1'b0;
`endif

    always_comb begin
        ret_value  = hd.value;
        ret_mp     = hd.mispredict;
        ret_target = hd.target;
        if (head_cdb && !hd.ready) begin
            ret_value  = cdb_data;
            ret_mp     = cdb_mispredict;
            ret_target = cdb_target;
        end
        retire    = !empty && hd.busy && (hd.ready || head_cdb);
        flush_now = retire && hd.is_branch && ret_mp;
        // the cycle the flush pulse is out, the front end is still on the wrong path
        alloc     = disp_valid && !full && !flush_now && !flush;
        cdb_wr    = cdb_valid && tag_ok(cdb_tag) && ent[cdb_idx].busy && !flush_now;
    end

    always_comb begin
        new_ent            = ENTRY_CLEAR;
        new_ent.busy       = 1'b1;
        new_ent.rd         = disp_rd;
        new_ent.is_branch  = disp_is_branch;
        new_ent.target     = disp_pc_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_SIZE; i++)
                ent[i] <= ENTRY_CLEAR;
        end else if (rdy) begin
            if (flush_now) begin
                for (int i = 0; i < ROB_SIZE; i++)
                    ent[i] <= ENTRY_CLEAR;
            end else begin
                if (alloc)
                    ent[tail] <= new_ent;
                if (cdb_wr) begin
                    ent[cdb_idx].ready      <= 1'b1;
                    ent[cdb_idx].value      <= cdb_data;
                    ent[cdb_idx].mispredict <= cdb_mispredict;
                    ent[cdb_idx].target     <= cdb_target;
                end
                if (retire) begin
                    ent[head].busy  <= 1'b0;
                    ent[head].ready <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_dest  <= '0;
            commit_tag   <= '0;
            commit_data  <= '0;
            flush        <= 1'b0;
            flush_pc     <= '0;
        end else if (rdy) begin
            commit_valid <= retire && !flush_now;
            flush        <= flush_now;
            flush_pc     <= flush_now ? ret_target : '0;
            if (retire && !flush_now) begin
                commit_dest <= hd.is_branch ? '0 : hd.rd;
                commit_tag  <= head_tag;
                commit_data <= ret_value;
            end
        end
    end

    function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] t);
        logic [DATA_W:0] r;
        r = '0;
        if (tag_ok(t) && ent[tag_idx(t)].busy && ent[tag_idx(t)].ready)
            r = {1'b1, ent[tag_idx(t)].value};
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_valid && tag_ok(t) && (cdb_tag == t))
            r = {1'b1, cdb_data};
`endif
        return r;
    endfunction

    assign {query_rdy1, query_data1} = lookup(query_tag1);
    assign {query_rdy2, query_data2} = lookup(query_tag2);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: expected commits/flushes are queued and checked by a separate monitor.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        disp_valid;
    logic [4:0]  disp_rd;
    logic        disp_is_branch;
    logic [31:0] disp_pc_next;
    logic        rob_full;
    logic [4:0]  alloc_tag;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_mispredict;
    logic [31:0] cdb_target;
    logic [4:0]  query_tag1;
    logic [4:0]  query_tag2;
    logic        query_rdy1;
    logic        query_rdy2;
    logic [31:0] query_data1;
    logic [31:0] query_data2;
    logic        commit_valid;
    logic [4:0]  commit_dest;
    logic [4:0]  commit_tag;
    logic [31:0] commit_data;
    logic        flush;
    logic [31:0] flush_pc;

    typedef struct {
        bit          is_flush;
        logic [4:0]  dest;
        logic [4:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    reorder_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .disp_valid     (disp_valid),
        .disp_rd        (disp_rd),
        .disp_is_branch (disp_is_branch),
        .disp_pc_next   (disp_pc_next),
        .rob_full       (rob_full),
        .alloc_tag      (alloc_tag),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_mispredict (cdb_mispredict),
        .cdb_target     (cdb_target),
        .query_tag1     (query_tag1),
        .query_tag2     (query_tag2),
        .query_rdy1     (query_rdy1),
        .query_rdy2     (query_rdy2),
        .query_data1    (query_data1),
        .query_data2    (query_data2),
        .commit_valid   (commit_valid),
        .commit_dest    (commit_dest),
        .commit_tag     (commit_tag),
        .commit_data    (commit_data),
        .flush          (flush),
        .flush_pc       (flush_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_commit(input logic [4:0] dest, input logic [4:0] tag, input logic [31:0] data);
        exp_t e;
        e.is_flush = 1'b0;
        e.dest = dest;
        e.tag  = tag;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic expect_flush(input logic [31:0] pc);
        exp_t e;
        e.is_flush = 1'b1;
        e.dest = '0;
        e.tag  = '0;
        e.data = pc;
        q.push_back(e);
    endtask

    task automatic dispatch(input logic [4:0] rd, input logic br, input logic [31:0] pcn);
        disp_valid     = 1'b1;
        disp_rd        = rd;
        disp_is_branch = br;
        disp_pc_next   = pcn;
        tick();
        disp_valid     = 1'b0;
        disp_is_branch = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] tag, input logic [31:0] data, input logic mp, input logic [31:0] tgt);
        cdb_valid      = 1'b1;
        cdb_tag        = tag;
        cdb_data       = data;
        cdb_mispredict = mp;
        cdb_target     = tgt;
        tick();
        cdb_valid      = 1'b0;
        cdb_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++)
            tick();
        chk("drain_pending", q.size(), 0);
    endtask

    // monitor: every commit or flush pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && (commit_valid || flush)) begin
            if (q.size() == 0) begin
                chk("unexpected_output", {commit_valid, flush}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.is_flush) begin
                    chk("flush_pulse", {commit_valid, flush}, 2'b01);
                    chk("flush_pc", flush_pc, e.data);
                end else begin
                    chk("commit_pulse", {commit_valid, flush}, 2'b10);
                    chk("commit_dest", commit_dest, e.dest);
                    chk("commit_tag", commit_tag, e.tag);
                    chk("commit_data", commit_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1; rdy = 1'b1;
        disp_valid = 1'b0; disp_rd = '0; disp_is_branch = 1'b0; disp_pc_next = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; cdb_mispredict = 1'b0; cdb_target = '0;
        query_tag1 = '0; query_tag2 = '0;
        do_reset();

        // reset state
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_commit_data", commit_data, 0);
        chk("rst_flush", flush, 0);
        chk("rst_flush_pc", flush_pc, 0);
        chk("rst_full", rob_full, 0);
        chk("rst_alloc_tag", alloc_tag, 1);

        // frozen while rdy is low
        rdy = 1'b0;
        dispatch(5'd3, 1'b0, 32'h0);
        rdy = 1'b1;
        chk("rdy_low_alloc_tag", alloc_tag, 1);

        // single entry round trip
        dispatch(5'd5, 1'b0, 32'h4);
        chk("alloc_tag_after1", alloc_tag, 2);
        expect_commit(5'd5, 5'd1, 32'hDEAD);
        cdb(5'd1, 32'hDEAD, 1'b0, 32'h0);
`ifdef ROB_CDB_BYPASS_EN
        chk("t1_commit_latency", commit_valid, 1);
`else
        chk("t1_commit_early", commit_valid, 0);
        tick();
        chk("t1_commit_latency", commit_valid, 1);
`endif
        drain();

        // out-of-order results retire in program order on consecutive cycles
        do_reset();
        dispatch(5'd10, 1'b0, 32'h0);
        dispatch(5'd11, 1'b0, 32'h0);
        dispatch(5'd12, 1'b0, 32'h0);
        expect_commit(5'd10, 5'd1, 32'd1);
        expect_commit(5'd11, 5'd2, 32'd2);
        expect_commit(5'd12, 5'd3, 32'd3);
        cdb(5'd3, 32'd3, 1'b0, 32'h0);
        cdb(5'd2, 32'd2, 1'b0, 32'h0);
        chk("t2_no_early_commit", commit_valid, 0);
        cdb(5'd1, 32'd1, 1'b0, 32'h0);
`ifndef ROB_CDB_BYPASS_EN
        tick();
`endif
        for (int k = 1; k <= 3; k++) begin
            chk("t2_consecutive_valid", commit_valid, 1);
            chk("t2_consecutive_tag", commit_tag, k);
            tick();
        end
        drain();

        // fill, overflow attempt, wrap-around
        do_reset();
        for (int i = 0; i < 16; i++)
            dispatch(5'(i + 1), 1'b0, 32'h0);
        chk("t3_full", rob_full, 1);
        chk("t3_full_alloc_tag", alloc_tag, 1);
        dispatch(5'd31, 1'b0, 32'h0);
        chk("t3_still_full", rob_full, 1);
        expect_commit(5'd1, 5'd1, 32'h100);
        cdb(5'd1, 32'h100, 1'b0, 32'h0);
        tick();
        tick();
        chk("t3_not_full", rob_full, 0);
        chk("t3_wrap_alloc_tag", alloc_tag, 1);
        dispatch(5'd20, 1'b0, 32'h0);
        chk("t3_refull", rob_full, 1);
        for (int t = 2; t <= 16; t++) begin
            expect_commit(5'(t), 5'(t), 32'h200 + t);
            cdb(5'(t), 32'h200 + t, 1'b0, 32'h0);
        end
        expect_commit(5'd20, 5'd1, 32'h77);
        cdb(5'd1, 32'h77, 1'b0, 32'h0);
        drain();

        // mispredicted branch behind a normal instruction
        do_reset();
        dispatch(5'd7, 1'b0, 32'h40);
        dispatch(5'd9, 1'b1, 32'h44);
        dispatch(5'd9, 1'b0, 32'h48);
        expect_commit(5'd7, 5'd1, 32'h11);
        expect_flush(32'h100);
        cdb(5'd2, 32'h0, 1'b1, 32'h100);
        cdb(5'd1, 32'h11, 1'b0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (flush) found = 1'b1;
            else tick();
        end
        chk("t4_flush_seen", found, 1);
        chk("t4_flush_pc", flush_pc, 32'h100);
        tick();
        chk("t4_flush_one_cycle", flush, 0);
        chk("t4_empty_after_flush", rob_full, 0);
        chk("t4_alloc_tag_after_flush", alloc_tag, 1);
        cdb(5'd3, 32'h33, 1'b0, 32'h0);
        dispatch(5'd4, 1'b0, 32'h0);
        expect_commit(5'd4, 5'd1, 32'h99);
        cdb(5'd1, 32'h99, 1'b0, 32'h0);
        drain();

        // operand queries
        do_reset();
        for (int i = 1; i <= 4; i++)
            dispatch(5'(i), 1'b0, 32'h0);
        expect_commit(5'd1, 5'd1, 32'hA1);
        expect_commit(5'd2, 5'd2, 32'hA2);
        expect_commit(5'd3, 5'd3, 32'd7);
        expect_commit(5'd4, 5'd4, 32'h55);
        cdb(5'd4, 32'h55, 1'b0, 32'h0);
        query_tag1 = 5'd4;
        query_tag2 = 5'd0;
        #1;
        chk("t5_q1_rdy", query_rdy1, 1);
        chk("t5_q1_data", query_data1, 32'h55);
        chk("t5_q2_tag0_rdy", query_rdy2, 0);
        chk("t5_q2_tag0_data", query_data2, 0);
        query_tag2 = 5'd3;
        #1;
        chk("t5_q2_pending_rdy", query_rdy2, 0);
        cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_data = 32'd7;
        query_tag1 = 5'd3;
        #1;
`ifdef ROB_CDB_BYPASS_EN
        chk("t5_bypass_rdy", query_rdy1, 1);
        chk("t5_bypass_data", query_data1, 32'd7);
`else
        chk("t5_nobypass_rdy", query_rdy1, 0);
`endif
        tick();
        cdb_valid = 1'b0;
        #1;
        chk("t5_captured_rdy", query_rdy1, 1);
        chk("t5_captured_data", query_data1, 32'd7);
        cdb(5'd1, 32'hA1, 1'b0, 32'h0);
        cdb(5'd2, 32'hA2, 1'b0, 32'h0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer on the dispatch-to-commit path of the out-of-order core.
- Allocates a rename tag per dispatched instruction and captures results from the common data bus (CDB).
- Retires results in program order into the register file's commit port.
- Raises a one-cycle flush on a mispredicted branch, which clears all register-file dependencies.
- Tags are 5-bit. Tag 0 means "no dependency", so entry i carries tag i+1.

Parameters:
- ROB_SIZE, 16: number of entries. Legal range 2..31.
- TAG_W, 5: tag width. Must hold ROB_SIZE (tag value ROB_SIZE is legal).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; all state frozen when low
- disp_valid  in  1  dispatch request this cycle
- disp_rd  in  5  destination register; 0 for branch/store
- disp_is_branch  in  1  entry is a branch
- disp_pc_next  in  32  fall-through PC of the dispatched instruction
- rob_full  out  1  no free entry (combinational)
- alloc_tag  out  5  tag the current request receives: tail+1 (combinational)
- cdb_valid  in  1  result broadcast
- cdb_tag  in  5  producing tag
- cdb_data  in  32  result value
- cdb_mispredict  in  1  branch outcome differs from prediction
- cdb_target  in  32  correct PC for a mispredicted branch
- query_tag1, query_tag2  in  5  operand tags from dispatch
- query_rdy1, query_rdy2  out  1  queried entry already has its result (combinational)
- query_data1, query_data2  out  32  that result
- commit_valid  out  1  registered; one pulse per retired entry
- commit_dest  out  5  destination register
- commit_tag  out  5  tag of the retired entry, so the register file can clear only a matching dependency
- commit_data  out  32  retired value
- flush  out  1  registered one-cycle wrong-commit pulse
- flush_pc  out  32  redirect PC, valid while flush is high

Behaviour:
- Reset: head=0, tail=0, count=0, all busy/ready=0. commit_valid, commit_dest, commit_tag, commit_data, flush and flush_pc are all 0.
- Entry fields: busy, ready, rd, is_branch, mispredict, value, target.
- Allocate when disp_valid && !rob_full && !flush:
  - write entry[tail] with busy=1, ready=0;
  - tail wraps to 0 after ROB_SIZE-1.
  - disp_valid while full is ignored; the dispatcher must stall on rob_full.
- CDB capture: on cdb_valid for a busy entry at index cdb_tag-1, set ready=1, value=cdb_data, mispredict=cdb_mispredict and target=cdb_target.
  - cdb_valid with tag 0 or a non-busy entry is ignored.
- Commit: when entry[head] is busy && ready, retire it in that cycle.
  - On the next edge commit_valid=1, commit_dest=rd (forced 0 for branches), commit_tag=head+1 and commit_data=value.
  - Otherwise commit_valid=0.
  - Maximum one commit per cycle. Retire-to-register-file latency is 1 cycle after the retire decision.
- Mispredict: retiring a branch with mispredict=1 registers flush=1 and flush_pc=target (commit_valid=0), and clears all entries, head, tail and count in the same edge.
  - Concurrent dispatch and CDB writes in that cycle are dropped.
  - flush holds for exactly one cycle.
- Simultaneous allocate and commit: count unchanged, both pointers advance.
- Full: count==ROB_SIZE. Empty: count==0, nothing retires.
- CDB result and retirement for the same entry in the same cycle: the entry is not ready yet, so it retires next cycle.
- Query ports: query_rdy=busy&&ready of entry tag-1. Tag 0 gives rdy=0, data=0.
- rdy low: no state change; registered outputs hold their values.
- Reset mid-operation overrides everything, including a pending flush.

Optional Feature:
- ROB_CDB_BYPASS_EN defined:
  - query ports also match the current-cycle CDB broadcast: cdb_valid && cdb_tag==query_tag gives rdy=1, data=cdb_data;
  - the head entry may retire in the same cycle its CDB result arrives, using cdb_data.
- Undefined: behaviour exactly as above, and a result becomes visible one cycle after capture.

Decomposition:
- Shared package/header: ROB_SIZE, TAG_W, the tag-0 "none" constant, and the entry record fields.
- Natural sub-module: rob_ptr_ctrl, holding the head/tail/count wrap arithmetic plus the full/empty flags.
- Entry storage and the retire/flush logic remain in reorder_buffer.

Test Plan:
- Reset, then dispatch rd=5 (tag 1). CDB tag1 data 0xDEAD. Expect next-cycle commit_valid=1, dest=5, tag=1, data=0xDEAD.
- Dispatch tags 1,2,3. CDB order 3,2,1 with data 3,2,1. Expect commits in order tag1, tag2, tag3, on consecutive cycles once tag1 arrives.
- Dispatch 16 entries. Expect rob_full=1. A 17th disp_valid is ignored. Commit one, then dispatch: alloc_tag=1 (wrap-around).
- Branch tag 2 behind tag 1, CDB mispredict target 0x100. Expect tag1 commits, then flush=1 with flush_pc=0x100 for one cycle, then rob_full=0, count 0, next alloc_tag=1.
- Query tag 4 after its CDB data 0x55. Expect query_rdy1=1, query_data1=0x55. Query tag 0: rdy=0.
- With ROB_CDB_BYPASS_EN: query tag 3 in the same cycle as CDB tag3 data 7. Expect rdy=1, data=7 combinationally.
